// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the uart_tx_arbiter and the shared uart_tx.
// slave = arbiter side, master = producers plus serializer side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic [ID_W-1:0]              active_id;
  logic                         arb_busy;
  logic                         tx_en;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_busy;
  logic                         tx_done;
  logic                         timeout_err;

  modport slave (
    input  req, req_data, tx_busy, tx_done,
    output grant, done, active_id, arb_busy, tx_en, tx_data, timeout_err
  );

  modport master (
    output req, req_data, tx_busy, tx_done,
    input  grant, done, active_id, arb_busy, tx_en, tx_data, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte requesters.
// Optional watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              arst_n,
  uart_tx_arbiter_if.slave  bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t               state_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      active_id_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 tx_en_q;
  logic                 arb_busy_q;
  logic [DATA_BITS-1:0] tx_data_q;

  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];
  logic                 found_d;
  logic [ID_W-1:0]      sel_d;
  logic [DATA_BITS-1:0] sel_data_d;
  logic                 in_xfer;
  logic                 xfer_end_d;
  logic                 timeout_hit;
  int unsigned          idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = bus.req_data[g*DATA_BITS +: DATA_BITS];
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_err_q;
  assign timeout_hit     = in_xfer && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign bus.timeout_err    = 1'b0;
`endif

  // Scan starts one past the last winner so the previous owner is considered last.
  always_comb begin
    found_d    = 1'b0;
    sel_d      = '0;
    sel_data_d = '0;
    idx        = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found_d && bus.req[ID_W'(idx)]) begin
        found_d    = 1'b1;
        sel_d      = ID_W'(idx);
        sel_data_d = req_bytes[ID_W'(idx)];
      end
    end
  end

  assign in_xfer    = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
  assign xfer_end_d = in_xfer && (bus.tx_done || timeout_hit);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      active_id_q   <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      tx_en_q       <= 1'b0;
      arb_busy_q    <= 1'b0;
      tx_data_q     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      tx_en_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      if (in_xfer && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      if (timeout_hit) timeout_err_q <= 1'b1;
`endif
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            tx_data_q   <= sel_data_d;
            active_id_q <= sel_d;
            ptr_q       <= sel_d;
            grant_q     <= NUM_REQ'(1) << sel_d;
            tx_en_q     <= 1'b1;
            arb_busy_q  <= 1'b1;
            state_q     <= S_LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        S_LAUNCH: state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY, S_WAIT_DONE: begin
          // A frame fast enough to finish before busy is seen ends straight from WAIT_BUSY.
          if (xfer_end_d) begin
            done_q     <= NUM_REQ'(1) << active_id_q;
            arb_busy_q <= 1'b0;
            state_q    <= S_IDLE;
          end else if ((state_q == S_WAIT_BUSY) && bus.tx_busy) begin
            state_q <= S_WAIT_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.active_id = active_id_q;
  assign bus.arb_busy  = arb_busy_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.tx_data   = tx_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a behavioural uart_tx stub and a round-robin model.
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned TO = 1000;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int ntests = 0;
  int nfail  = 0;
  int model_ptr = NR - 1;
  logic [7:0] dat [NR];
  bit stub_fast = 0, stub_silent = 0, stub_stray = 0;
  int frame_min = 3, frame_max = 20;

  // uart_tx stand-in: busy for a random frame length, then a one-cycle done pulse
  initial begin
    int len;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (stub_stray) begin
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        stub_stray = 0;
      end else if (arst_n && bus.tx_en && !stub_silent) begin
        len = stub_fast ? 0 : int'($urandom_range(frame_min, frame_max));
        @(negedge clk);
        bus.tx_busy = (len != 0);
        for (int c = 0; c < len && arst_n; c++) @(negedge clk);
        bus.tx_busy = 1'b0;
        if (arst_n) begin
          bus.tx_done = 1'b1;
          @(negedge clk);
          bus.tx_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void pack_data();
    bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
  endfunction

  function automatic int rr_next(input logic [3:0] pend);
    for (int k = 1; k <= int'(NR); k++) begin
      int c;
      c = (model_ptr + k) % NR;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.grant != 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_done(input logic [7:0] sent, input int budget,
                           output bit ok, output int cycles, output bit bad);
    ok = 0; cycles = 0; bad = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cycles++;
      if (bus.done != 0) begin
        ok = 1;
        break;
      end
      if (bus.tx_data !== sent || bus.grant !== 4'b0 || bus.tx_en !== 1'b0 || bus.arb_busy !== 1'b1)
        bad = 1;
    end
  endtask

  task automatic serve_one(input logic [3:0] pend, input bit drop);
    int exp, cyc;
    bit ok, bad;
    logic [3:0] exp_oh;
    logic [7:0] sent;
    exp = rr_next(pend);
    exp_oh = 4'b1 << exp;
    wait_grant(ok);
    ntests++;
    if (!ok) begin
      nfail++;
      $display("FAIL grant_wait: got no grant, expected %b", exp_oh);
      return;
    end
    ntests++;
    if (bus.grant !== exp_oh || bus.active_id !== 2'(exp)) begin
      nfail++;
      $display("FAIL grant_sel: got grant=%b id=%0d, expected grant=%b id=%0d",
               bus.grant, bus.active_id, exp_oh, exp);
    end
    ntests++;
    if (bus.tx_en !== 1'b1 || bus.tx_data !== dat[exp] || bus.arb_busy !== 1'b1) begin
      nfail++;
      $display("FAIL launch: got tx_en=%b data=%h busy=%b, expected 1 %h 1",
               bus.tx_en, bus.tx_data, bus.arb_busy, dat[exp]);
    end
    sent = dat[exp];
    model_ptr = exp;
    if (drop) bus.req[exp] = 1'b0;
    else begin
      dat[exp] = 8'($urandom);
      pack_data();
    end
    wait_done(sent, 400, ok, cyc, bad);
    ntests++;
    if (!ok) begin
      nfail++;
      $display("FAIL done_wait: got no done in %0d cycles, expected %b", cyc, exp_oh);
      return;
    end
    ntests++;
    if (bad) begin
      nfail++;
      $display("FAIL hold: got tx_data/grant/tx_en/busy disturbed mid-frame, expected %h held", sent);
    end
    ntests++;
    if (bus.done !== exp_oh || bus.arb_busy !== 1'b0) begin
      nfail++;
      $display("FAIL done_sel: got done=%b busy=%b, expected done=%b busy=0",
               bus.done, bus.arb_busy, exp_oh);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [20:0] snap;
    snap = {bus.grant, bus.done, bus.active_id, bus.arb_busy, bus.tx_en, bus.tx_data, bus.timeout_err};
    ntests++;
    if (snap !== 21'b0) begin
      nfail++;
      $display("FAIL %s: got outputs %h, expected 0", name, snap);
    end
  endtask

  task automatic test_reset();
    bus.req = '0;
    for (int i = 0; i < int'(NR); i++) dat[i] = '0;
    pack_data();
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    arst_n = 1'b1;
    model_ptr = NR - 1;
    repeat (2) @(negedge clk);
    check_all_zero("idle_no_req");
  endtask

  task automatic test_round_robin();
    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3; dat[3] = 8'hD4;
    pack_data();
    bus.req = 4'b1111;
    repeat (4) serve_one(4'b1111, 0);
    bus.req = '0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < int'(NR); i++) dat[i] = 8'($urandom);
    pack_data();
    bus.req = 4'b1001;
    repeat (4) serve_one(4'b1001, 0);
    bus.req = '0;
  endtask

  task automatic test_single();
    dat[0] = 8'h55;
    pack_data();
    bus.req = 4'b0001;
    serve_one(4'b0001, 1);
  endtask

  task automatic test_random();
    logic [3:0] pat;
    for (int it = 0; it < 12; it++) begin
      pat = 4'($urandom_range(1, 15));
      frame_max = int'($urandom_range(3, 30));
      for (int i = 0; i < int'(NR); i++) dat[i] = 8'($urandom);
      pack_data();
      bus.req = pat;
      repeat ($urandom_range(1, 3)) serve_one(pat, 0);
      bus.req = '0;
    end
    frame_max = 20;
  endtask

  task automatic test_ignore_pulse();
    bit ok, bad;
    int cyc;
    logic [7:0] sent;
    frame_min = 10;
    dat[0] = 8'($urandom);
    pack_data();
    sent = dat[0];
    bus.req = 4'b0001;
    wait_grant(ok);
    bus.req = '0;
    model_ptr = 0;
    ntests++;
    if (!ok || bus.grant !== 4'b0001) begin
      nfail++;
      $display("FAIL pulse_grant: got %b, expected 0001", bus.grant);
    end
    repeat (3) @(negedge clk);
    dat[1] = ~sent;
    pack_data();
    bus.req[1] = 1'b1;
    @(negedge clk);
    bus.req[1] = 1'b0;
    wait_done(sent, 400, ok, cyc, bad);
    ntests++;
    if (!ok || bad) begin
      nfail++;
      $display("FAIL pulse_hold: got done_seen=%b disturbed=%b, expected 1 0", ok, bad);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.grant !== 4'b0 || bus.arb_busy !== 1'b0) bad = 1;
    end
    ntests++;
    if (bad) begin
      nfail++;
      $display("FAIL pulse_nogrant: got late grant/busy, expected none");
    end
    frame_min = 3;
  endtask

  task automatic test_stray_done();
    bit bad;
    bad = 0;
    bus.req = '0;
    stub_stray = 1;
    repeat (6) begin
      @(negedge clk);
      if (bus.done !== 4'b0 || bus.arb_busy !== 1'b0) bad = 1;
    end
    ntests++;
    if (bad) begin
      nfail++;
      $display("FAIL stray_done: got done/busy reaction, expected none");
    end
  endtask

  task automatic test_fast_frame();
    logic [3:0] pat;
    stub_fast = 1;
    pat = 4'b1 << $urandom_range(0, 3);
    dat[0] = 8'($urandom); dat[1] = 8'($urandom); dat[2] = 8'($urandom); dat[3] = 8'($urandom);
    pack_data();
    bus.req = pat;
    serve_one(pat, 1);
    stub_fast = 0;
  endtask

  task automatic test_reset_mid();
    bit ok, bad;
    frame_min = 15;
    dat[1] = 8'hAF;
    pack_data();
    bus.req = 4'b0010;
    wait_grant(ok);
    bus.req = '0;
    repeat (4) @(negedge clk);
    #2 arst_n = 1'b0;
    #1 check_all_zero("reset_mid");
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done !== 4'b0) bad = 1;
    end
    arst_n = 1'b1;
    model_ptr = NR - 1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 4'b0 || bus.arb_busy !== 1'b0) bad = 1;
    end
    ntests++;
    if (bad) begin
      nfail++;
      $display("FAIL reset_nodone: got done after abort, expected none");
    end
    frame_min = 3;
    dat[2] = 8'h3C;
    pack_data();
    bus.req = 4'b0100;
    serve_one(4'b0100, 1);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, bad;
    int cyc;
    stub_silent = 1;
    dat[0] = 8'($urandom);
    pack_data();
    bus.req = 4'b0001;
    wait_grant(ok);
    bus.req = '0;
    model_ptr = 0;
    wait_done(dat[0], 1200, ok, cyc, bad);
    ntests++;
    if (!ok || cyc < 998 || cyc > 1002) begin
      nfail++;
      $display("FAIL timeout_latency: got done_seen=%b after %0d cycles, expected ~%0d", ok, cyc, TO);
    end
    ntests++;
    if (bus.timeout_err !== 1'b1 || bus.done !== 4'b0001 || bus.arb_busy !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_flag: got err=%b done=%b busy=%b, expected 1 0001 0",
               bus.timeout_err, bus.done, bus.arb_busy);
    end
    stub_silent = 0;
    dat[1] = 8'($urandom);
    pack_data();
    bus.req = 4'b0010;
    serve_one(4'b0010, 1);
    ntests++;
    if (bus.timeout_err !== 1'b1) begin
      nfail++;
      $display("FAIL timeout_sticky: got %b, expected 1", bus.timeout_err);
    end
  endtask
`else
  task automatic test_timeout();
    ntests++;
    if (bus.timeout_err !== 1'b0) begin
      nfail++;
      $display("FAIL timeout_tied: got %b, expected 0", bus.timeout_err);
    end
  endtask
`endif

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_single();
    test_random();
    test_ignore_pulse();
    test_stray_done();
    test_fast_frame();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
